// File: rtl/csr_exec_pkg.sv
// Shared types and constants for the SYSTEM-instruction CSR sequencer.
package csr_exec_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_CSRRW = 3'd0,
        OP_CSRRS = 3'd1,
        OP_CSRRC = 3'd2,
        OP_ECALL = 3'd3,
        OP_MRET  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [XLEN-1:0] CAUSE_ECALL_M = 32'd11;
    localparam logic [XLEN-1:0] CAUSE_ILLEGAL = 32'd2;

    // Undefined encodings 5..7 fall back to MRET.
    function automatic op_e decode_op(input logic [2:0] raw);
        case (raw)
            3'd0:    return OP_CSRRW;
            3'd1:    return OP_CSRRS;
            3'd2:    return OP_CSRRC;
            3'd3:    return OP_ECALL;
            default: return OP_MRET;
        endcase
    endfunction

    function automatic logic is_known_csr(input logic [11:0] addr);
        return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
               (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
    endfunction

endpackage

// File: rtl/csr_exec_if.sv
// Bundle of the op-in, result-out, CSR-port and trap signals around csr_exec.
interface csr_exec_if;
    import csr_exec_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [11:0]     in_csr;
    logic [XLEN-1:0] in_src;
    logic            in_src_zero;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      in_rd;

    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_rd;
    logic            out_rd_wen;
    logic [XLEN-1:0] out_rd_wdata;
    logic            out_redirect;
    logic [XLEN-1:0] out_redirect_pc;

    logic [31:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_wen;
    logic [XLEN-1:0] csr_rdata;

    logic            exception;
    logic [XLEN-1:0] exception_pc;
    logic [XLEN-1:0] exception_cause;

    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;

    modport slave (
        input  in_valid, in_op, in_csr, in_src, in_src_zero, in_pc, in_rd,
        output in_ready,
        output out_valid, out_rd, out_rd_wen, out_rd_wdata, out_redirect, out_redirect_pc,
        input  out_ready,
        output csr_addr, csr_wdata, csr_wen,
        input  csr_rdata,
        output exception, exception_pc, exception_cause,
        input  mtvec, mepc
    );

    modport master (
        output in_valid, in_op, in_csr, in_src, in_src_zero, in_pc, in_rd,
        input  in_ready,
        input  out_valid, out_rd, out_rd_wen, out_rd_wdata, out_redirect, out_redirect_pc,
        output out_ready,
        input  csr_addr, csr_wdata, csr_wen,
        output csr_rdata,
        input  exception, exception_pc, exception_cause,
        output mtvec, mepc
    );

endinterface

// File: rtl/csr_exec_rmw.sv
// Combinational CSR read-modify-write: new value and whether the write happens.
module csr_rmw
    import csr_exec_pkg::*;
(
    input  op_e             op_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] src_i,
    input  logic            src_zero_i,
    output logic [XLEN-1:0] new_o,
    output logic            wen_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        new_o = old_i;
        wen_o = 1'b0;
        case (op_i)
            OP_CSRRW: begin
                new_o = src_i;
                wen_o = 1'b1;
            end
            // Set/clear with a zero source is a pure read and must not touch the CSR.
            OP_CSRRS: begin
                new_o = old_i | src_i;
                wen_o = !src_zero_i;
            end
            OP_CSRRC: begin
                new_o = old_i & ~src_i;
                wen_o = !src_zero_i;
            end
            default: begin
                new_o = old_i;
                wen_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_exec.sv
// CSR/ECALL/MRET sequencer driving the CSR file's single access port.
// Optional CSR_ILLEGAL_TRAP_EN: unrecognised CSR addresses trap with cause 2.
module csr_exec
    import csr_exec_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    csr_exec_if.slave bus
);

    state_e          state_q;
    op_e             op_q;
    logic [XLEN-1:0] src_q;
    logic            src_zero_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] old_q;
    logic            trap_q;

    logic            out_valid_q;
    logic [4:0]      out_rd_q;
    logic            out_rd_wen_q;
    logic [XLEN-1:0] out_rd_wdata_q;
    logic            out_redirect_q;
    logic [XLEN-1:0] out_redirect_pc_q;
    logic [31:0]     csr_addr_q;
    logic [XLEN-1:0] csr_wdata_q;
    logic            csr_wen_q;
    logic            exception_q;
    logic [XLEN-1:0] exception_pc_q;
    logic [XLEN-1:0] exception_cause_q;

    logic [XLEN-1:0] wdata_d;
    logic            wen_d;

    // Fed straight from csr_rdata so the write value is ready at the end of READ.
    csr_rmw u_rmw (
        .op_i       (op_q),
        .old_i      (bus.csr_rdata),
        .src_i      (src_q),
        .src_zero_i (src_zero_q),
        .new_o      (wdata_d),
        .wen_o      (wen_d)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q           <= ST_IDLE;
            op_q              <= OP_CSRRW;
            src_q             <= '0;
            src_zero_q        <= 1'b0;
            rd_q              <= '0;
            old_q             <= '0;
            trap_q            <= 1'b0;
            out_valid_q       <= 1'b0;
            out_rd_q          <= '0;
            out_rd_wen_q      <= 1'b0;
            out_rd_wdata_q    <= '0;
            out_redirect_q    <= 1'b0;
            out_redirect_pc_q <= '0;
            csr_addr_q        <= '0;
            csr_wdata_q       <= '0;
            csr_wen_q         <= 1'b0;
            exception_q       <= 1'b0;
            exception_pc_q    <= '0;
            exception_cause_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op_q           <= decode_op(bus.in_op);
                        src_q          <= bus.in_src;
                        src_zero_q     <= bus.in_src_zero;
                        rd_q           <= bus.in_rd;
                        trap_q         <= 1'b0;
                        csr_addr_q     <= {20'b0, bus.in_csr};
                        // Qualified by the exception pulse; both trap kinds report this pc.
                        exception_pc_q <= bus.in_pc;
                        case (decode_op(bus.in_op))
                            OP_ECALL: begin
                                exception_q       <= 1'b1;
                                exception_cause_q <= CAUSE_ECALL_M;
                                state_q           <= ST_WRITE;
                            end
                            OP_MRET: begin
                                out_valid_q       <= 1'b1;
                                out_rd_q          <= bus.in_rd;
                                out_rd_wen_q      <= 1'b0;
                                out_redirect_q    <= 1'b1;
                                out_redirect_pc_q <= bus.mepc;
                                state_q           <= ST_RESP;
                            end
                            default: state_q <= ST_READ;
                        endcase
                    end
                end

                ST_READ: begin
                    old_q <= bus.csr_rdata;
`ifdef CSR_ILLEGAL_TRAP_EN
                    if (!is_known_csr(csr_addr_q[11:0])) begin
                        trap_q            <= 1'b1;
                        exception_q       <= 1'b1;
                        exception_cause_q <= CAUSE_ILLEGAL;
                    end else begin
                        csr_wen_q   <= wen_d;
                        csr_wdata_q <= wdata_d;
                    end
`else
                    csr_wen_q   <= wen_d;
                    csr_wdata_q <= wdata_d;
`endif
                    state_q <= ST_WRITE;
                end

                ST_WRITE: begin
                    csr_wen_q      <= 1'b0;
                    exception_q    <= 1'b0;
                    out_valid_q    <= 1'b1;
                    out_rd_q       <= rd_q;
                    out_rd_wdata_q <= old_q;
                    if (op_q == OP_ECALL || trap_q) begin
                        out_rd_wen_q      <= 1'b0;
                        out_redirect_q    <= 1'b1;
                        out_redirect_pc_q <= bus.mtvec;
                    end else begin
                        out_rd_wen_q   <= (rd_q != '0);
                        out_redirect_q <= 1'b0;
                    end
                    state_q <= ST_RESP;
                end

                ST_RESP: begin
                    if (bus.out_ready) begin
                        out_valid_q    <= 1'b0;
                        out_rd_wen_q   <= 1'b0;
                        out_redirect_q <= 1'b0;
                        state_q        <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready        = (state_q == ST_IDLE) && !rst;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_rd          = out_rd_q;
    assign bus.out_rd_wen      = out_rd_wen_q;
    assign bus.out_rd_wdata    = out_rd_wdata_q;
    assign bus.out_redirect    = out_redirect_q;
    assign bus.out_redirect_pc = out_redirect_pc_q;
    assign bus.csr_addr        = csr_addr_q;
    assign bus.csr_wdata       = csr_wdata_q;
    assign bus.csr_wen         = csr_wen_q;
    assign bus.exception       = exception_q;
    assign bus.exception_pc    = exception_pc_q;
    assign bus.exception_cause = exception_cause_q;

endmodule
